// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one shift-add multiplier between two requesters.
// Define MULT_ARB_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT_CYCLES (reported on oError).
module mult_arbiter #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iReq0_Valid,
  input  logic [WIDTH-1:0]     iReq0_A,
  input  logic [WIDTH-1:0]     iReq0_B,
  input  logic                 iReq1_Valid,
  input  logic [WIDTH-1:0]     iReq1_A,
  input  logic [WIDTH-1:0]     iReq1_B,
  output logic                 oAck0,
  output logic                 oAck1,
  output logic [2*WIDTH-1:0]   oProduct,
  output logic                 oError,
  output logic                 oMul_Valid,
  output logic [WIDTH-1:0]     oMul_A,
  output logic [WIDTH-1:0]     oMul_B,
  output logic                 oMul_Ack,
  input  logic                 iMul_Done,
  input  logic [2*WIDTH-1:0]   iMul_Product
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic               owner_q, owner_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               grant0, grant1;
  logic               timeout_hit;

  // rr_ptr only breaks ties; a lone request is always granted.
  assign grant0 = iReq0_Valid && (!iReq1_Valid || !rr_ptr_q);
  assign grant1 = iReq1_Valid && (!iReq0_Valid ||  rr_ptr_q);

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_comb begin
    cnt_d       = cnt_q;
    err_d       = err_q;
    timeout_hit = 1'b0;
    if (state_q == ST_LAUNCH) begin
      cnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      if (!iMul_Done && (cnt_q == CNT_LAST)) begin
        timeout_hit = 1'b1;
      end else if (!iMul_Done) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      err_d = !iMul_Done && (cnt_q == CNT_LAST);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign oError = (state_q == ST_RESP) && err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign oError         = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    prod_d   = prod_q;
    case (state_q)
      ST_IDLE: begin
        if (grant0) begin
          op_a_d  = iReq0_A;
          op_b_d  = iReq0_B;
          owner_d = 1'b0;
          state_d = ST_LAUNCH;
        end else if (grant1) begin
          op_a_d  = iReq1_A;
          op_b_d  = iReq1_B;
          owner_d = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (iMul_Done) begin
          prod_d  = iMul_Product;
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          prod_d  = '0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rr_ptr_d = ~owner_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= 1'b0;
      owner_q  <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      prod_q   <= prod_d;
    end
  end

  // Handshake outputs decode straight from state so they are single-cycle by construction.
  assign oMul_Valid = (state_q == ST_LAUNCH);
  assign oMul_Ack   = (state_q == ST_WAIT) && (iMul_Done || timeout_hit);
  assign oMul_A     = op_a_q;
  assign oMul_B     = op_b_q;
  assign oAck0      = (state_q == ST_RESP) && !owner_q;
  assign oAck1      = (state_q == ST_RESP) &&  owner_q;
  assign oProduct   = (state_q == ST_RESP) ? prod_q : '0;

endmodule
